par8_cmd_parser: RTL and testbench

- Consumes the received byte stream (rxd_data / rxd_data_ready) from the 8-bit parallel-bus receiver and decodes it into commands for the MD5 core.
- Produces the 128-bit target hash and a framed candidate-string byte stream, and generates the receiver's desync request.
- Has no backpressure because the receiver cannot stall. Every output is registered.

---
 rtl/par8_cmd_defs.sv | 19 +
 rtl/par8_byte_timeout.sv | 31 +++
 rtl/par8_cmd_parser.sv | 156 +++++++++++++++
 tb/tb_par8_cmd_parser.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/par8_cmd_defs.sv
// Shared opcode, state and framing definitions for the parallel-bus command path.
// The transmit-side packet builder imports the same constants.
package par8_cmd_defs;

  localparam logic [7:0] CMD_TEST     = 8'h01;
  localparam logic [7:0] CMD_SET_HASH = 8'h02;
  localparam logic [7:0] CMD_STR      = 8'h03;
  localparam logic [7:0] CMD_DESYNC   = 8'h04;

  localparam int HASH_BYTES_LEN = 16;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_HASH_BYTES = 2'd1,
    ST_STR_LEN    = 2'd2,
    ST_STR_BYTES  = 2'd3
  } state_e;

endpackage

// File: rtl/par8_byte_timeout.sv
// Inter-byte idle counter: clears on clr, counts while en, and flags expiry
// in the cycle the count sits at TIMEOUT_CYCLES-1 with no clear pending.
module par8_byte_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Expiry drops the parser to IDLE, which removes en, so this is a single pulse.
  assign expire = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/par8_cmd_parser.sv
// Decodes the receiver byte stream into test/desync pulses, a 128-bit target
// hash and a framed candidate-string stream. All outputs are registered.
//
// state         | meaning
// ST_IDLE       | waiting for an opcode byte
// ST_HASH_BYTES | collecting the 16 target-hash bytes
// ST_STR_LEN    | waiting for the string length byte
// ST_STR_BYTES  | forwarding string bytes until the count is used up
module par8_cmd_parser
  import par8_cmd_defs::*;
#(
  parameter int MAX_STR_LEN    = 64,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [7:0]   rxd_data,
  input  logic         rxd_data_ready,
  output logic         desync,
  output logic         test_pulse,
  output logic [127:0] hash_target,
  output logic         hash_target_valid,
  output logic [7:0]   str_data,
  output logic         str_valid,
  output logic         str_first,
  output logic         str_last,
  output logic [7:0]   str_len,
  output logic         cmd_error,
  output logic         busy
);

  localparam logic [7:0] MAX_LEN   = 8'(MAX_STR_LEN);
  localparam logic [7:0] HASH_LAST = 8'(HASH_BYTES_LEN - 1);

  state_e       state_q;
  logic         busy_q;
  logic [7:0]   hcnt_q;
  logic [7:0]   rem_q;
  logic [119:0] shadow_q;
  logic [127:0] hash_q;
  logic         desync_q, test_q, hv_q, err_q;
  logic [7:0]   sdata_q, slen_q;
  logic         svalid_q, sfirst_q, slast_q;
  logic         expire;

  par8_byte_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (rxd_data_ready || (state_q == ST_IDLE)),
    .en      (state_q != ST_IDLE),
    .expire  (expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      hcnt_q   <= '0;
      rem_q    <= '0;
      shadow_q <= '0;
      hash_q   <= '0;
      desync_q <= 1'b0;
      test_q   <= 1'b0;
      hv_q     <= 1'b0;
      err_q    <= 1'b0;
      sdata_q  <= '0;
      slen_q   <= '0;
      svalid_q <= 1'b0;
      sfirst_q <= 1'b0;
      slast_q  <= 1'b0;
    end else begin
      desync_q <= 1'b0;
      test_q   <= 1'b0;
      hv_q     <= 1'b0;
      err_q    <= 1'b0;
      svalid_q <= 1'b0;
      sfirst_q <= 1'b0;
      slast_q  <= 1'b0;
      if (rxd_data_ready) begin
        case (state_q)
          ST_IDLE: begin
            case (rxd_data)
              CMD_TEST:   test_q   <= 1'b1;
              CMD_DESYNC: desync_q <= 1'b1;
              CMD_SET_HASH: begin
                state_q <= ST_HASH_BYTES;
                busy_q  <= 1'b1;
                hcnt_q  <= '0;
              end
              CMD_STR: begin
                state_q <= ST_STR_LEN;
                busy_q  <= 1'b1;
              end
              default: err_q <= 1'b1;
            endcase
          end
          ST_HASH_BYTES: begin
            // Only 15 bytes need shadowing; the 16th goes straight into hash_q.
            shadow_q <= {shadow_q[111:0], rxd_data};
            if (hcnt_q == HASH_LAST) begin
              hash_q  <= {shadow_q, rxd_data};
              hv_q    <= 1'b1;
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              hcnt_q <= hcnt_q + 8'd1;
            end
          end
          ST_STR_LEN: begin
            if (rxd_data == 8'd0 || rxd_data > MAX_LEN) begin
              err_q   <= 1'b1;
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              slen_q  <= rxd_data;
              rem_q   <= rxd_data;
              state_q <= ST_STR_BYTES;
            end
          end
          ST_STR_BYTES: begin
            sdata_q  <= rxd_data;
            svalid_q <= 1'b1;
            sfirst_q <= (rem_q == slen_q);
            slast_q  <= (rem_q == 8'd1);
            rem_q    <= rem_q - 8'd1;
            if (rem_q == 8'd1) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end else if (expire) begin
        err_q   <= 1'b1;
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end
    end
  end

  assign desync            = desync_q;
  assign test_pulse        = test_q;
  assign hash_target       = hash_q;
  assign hash_target_valid = hv_q;
  assign str_data          = sdata_q;
  assign str_valid         = svalid_q;
  assign str_first         = sfirst_q;
  assign str_last          = slast_q;
  assign str_len           = slen_q;
  assign cmd_error         = err_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_par8_cmd_parser.sv
// Directed bench for par8_cmd_parser with a command-level reference model
// compared against the DUT on every falling clock edge.
module tb_par8_cmd_parser;

  localparam int TO   = 100;
  localparam int MAXL = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   rxd = '0;
  logic         rdy = 1'b0;
  logic         desync, test_pulse, hv, sv, sf, sl, err, busy;
  logic [127:0] hash;
  logic [7:0]   sd, slen;

  par8_cmd_parser #(.MAX_STR_LEN(MAXL), .TIMEOUT_CYCLES(TO)) dut (
    .clk               (clk),
    .reset_n           (rst_n),
    .rxd_data          (rxd),
    .rxd_data_ready    (rdy),
    .desync            (desync),
    .test_pulse        (test_pulse),
    .hash_target       (hash),
    .hash_target_valid (hv),
    .str_data          (sd),
    .str_valid         (sv),
    .str_first         (sf),
    .str_last          (sl),
    .str_len           (slen),
    .cmd_error         (err),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes of the command in progress are kept in a queue and
  // interpreted by position; silence is counted in whole cycles.
  logic [7:0]   cmd[$];
  int           idle;
  logic         e_desync, e_test, e_hv, e_sv, e_sf, e_sl, e_err, e_busy;
  logic [127:0] e_hash;
  logic [7:0]   e_sd, e_slen;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd.delete();
      idle = 0;
      {e_desync, e_test, e_hv, e_sv, e_sf, e_sl, e_err, e_busy} = '0;
      e_hash = '0;
      e_sd = '0;
      e_slen = '0;
    end else begin
      {e_desync, e_test, e_hv, e_sv, e_sf, e_sl, e_err} = '0;
      if (rdy) begin
        idle = 0;
        if (cmd.size() == 0) begin
          if (rxd == 8'h01) e_test = 1'b1;
          else if (rxd == 8'h04) e_desync = 1'b1;
          else if (rxd == 8'h02 || rxd == 8'h03) cmd.push_back(rxd);
          else e_err = 1'b1;
        end else if (cmd[0] == 8'h02) begin
          cmd.push_back(rxd);
          if (cmd.size() == 17) begin
            e_hash = '0;
            for (int i = 1; i <= 16; i++) e_hash = {e_hash[119:0], cmd[i]};
            e_hv = 1'b1;
            cmd.delete();
          end
        end else if (cmd.size() == 1) begin
          if (rxd == 0 || int'(rxd) > MAXL) begin
            e_err = 1'b1;
            cmd.delete();
          end else begin
            cmd.push_back(rxd);
            e_slen = rxd;
          end
        end else begin
          cmd.push_back(rxd);
          e_sv = 1'b1;
          e_sd = rxd;
          e_sf = (cmd.size() == 3);
          e_sl = (cmd.size() == int'(cmd[1]) + 2);
          if (e_sl) cmd.delete();
        end
      end else if (cmd.size() != 0) begin
        idle++;
        if (idle == TO) begin
          e_err = 1'b1;
          cmd.delete();
        end
      end
      e_busy = (cmd.size() != 0);
    end
  end

  int err_cnt = 0, sv_cnt = 0, hv_cnt = 0, test_cnt = 0, ds_cnt = 0;
  logic [7:0] last_sd = '0;
  logic last_sf = 1'b0, last_sl = 1'b0;

  always @(negedge clk) begin
    chk("desync", desync, e_desync);
    chk("test_pulse", test_pulse, e_test);
    chk("hash_valid", hv, e_hv);
    chk("hash_target", hash, e_hash);
    chk("str_valid", sv, e_sv);
    chk("str_first", sf, e_sf);
    chk("str_last", sl, e_sl);
    if (e_sv) chk("str_data", sd, e_sd);
    chk("str_len", slen, e_slen);
    chk("cmd_error", err, e_err);
    chk("busy", busy, e_busy);
    err_cnt  += int'(err);
    hv_cnt   += int'(hv);
    test_cnt += int'(test_pulse);
    ds_cnt   += int'(desync);
    if (sv) begin
      sv_cnt++;
      last_sd = sd;
      last_sf = sf;
      last_sl = sl;
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #2;
    rxd = b;
    rdy = 1'b1;
  endtask

  task automatic quiet(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      rdy = 1'b0;
      rxd = '0;
    end
  endtask

  int e0, s0, h0, t0, d0;

  task automatic snap();
    e0 = err_cnt; s0 = sv_cnt; h0 = hv_cnt; t0 = test_cnt; d0 = ds_cnt;
  endtask

  localparam logic [127:0] HASH_REF = 128'h000102030405060708090A0B0C0D0E0F;

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("reset_busy", busy, 0);
    chk("reset_hash", hash, 0);
    chk("reset_str_len", slen, 0);
    rst_n = 1'b1;
    quiet(2);

    // Bad lengths from reset: zero and MAX+1
    snap();
    send(8'h03); send(8'h00); send(8'h03); send(8'd65);
    quiet(3);
    chk("badlen_errors", err_cnt - e0, 2);
    chk("badlen_no_strobe", sv_cnt - s0, 0);
    chk("badlen_str_len", slen, 0);

    // Target hash back-to-back
    snap();
    send(8'h02);
    for (int i = 0; i < 16; i++) send(8'(i));
    quiet(3);
    chk("hash_pulses", hv_cnt - h0, 1);
    chk("hash_value", hash, HASH_REF);
    chk("model_hash", e_hash, HASH_REF);

    // String "abc" with 5-cycle gaps
    snap();
    send(8'h03); quiet(5); send(8'h03); quiet(5);
    send("a"); quiet(5); send("b"); quiet(5); send("c"); quiet(3);
    chk("abc_strobes", sv_cnt - s0, 3);
    chk("abc_str_len", slen, 3);
    chk("model_str_len", e_slen, 3);
    chk("abc_last_data", last_sd, 8'h63);
    chk("abc_last_flag", last_sl, 1);

    // Timeout after 8 hash bytes
    snap();
    send(8'h02);
    for (int i = 0; i < 8; i++) send(8'hA0 + 8'(i));
    quiet(TO + 5);
    chk("timeout_error", err_cnt - e0, 1);
    chk("timeout_busy", busy, 0);
    chk("timeout_hash_kept", hash, HASH_REF);
    chk("timeout_no_hv", hv_cnt - h0, 0);
    send(8'h01); quiet(3);
    chk("test_after_timeout", test_cnt - t0, 1);

    // Byte arriving in the expiry cycle is accepted
    snap();
    send(8'h03); send(8'h02); quiet(TO - 1); send("x"); quiet(TO - 1); send("y"); quiet(3);
    chk("edge_no_error", err_cnt - e0, 0);
    chk("edge_strobes", sv_cnt - s0, 2);

    // Timeout mid-string: emitted bytes stay, no str_last
    snap();
    send(8'h03); send(8'h04); send("p"); quiet(TO + 5);
    chk("strto_error", err_cnt - e0, 1);
    chk("strto_strobes", sv_cnt - s0, 1);
    chk("strto_no_last", last_sl, 0);

    // Desync and illegal opcode
    snap();
    send(8'h04); quiet(3); send(8'h7F); quiet(3);
    chk("desync_pulse", ds_cnt - d0, 1);
    chk("bad_opcode_error", err_cnt - e0, 1);
    chk("bad_opcode_idle", busy, 0);

    // Reset mid-string, then a one-byte string
    send(8'h03); send(8'h05); send("a"); send("b");
    @(posedge clk);
    #2;
    rdy = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_str_len", slen, 0);
    chk("midrst_hash", hash, 0);
    chk("midrst_valid", sv, 0);
    quiet(2);
    rst_n = 1'b1;
    quiet(2);
    snap();
    send(8'h03); send(8'h01); send("z"); quiet(3);
    chk("z_strobes", sv_cnt - s0, 1);
    chk("z_data", last_sd, 8'h7A);
    chk("z_first", last_sf, 1);
    chk("z_last", last_sl, 1);
    chk("z_str_len", slen, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
